median9_sched: RTL

MEDIAN9_SCHED -- requirements
Module: median9_sched

---
 rtl/median_pkg.sv | 29 ++
 rtl/median9_sched_if.sv | 22 ++
 rtl/sort3.sv | 39 +++
 rtl/median9_sched.sv | 132 +++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median-filter block family: FSM states, mode codes,
// fixed latency and default pixel width.
package median_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MED9_LATENCY  = 10;

  typedef enum logic [1:0] {
    ModeMedian = 2'b00,
    ModeMin    = 2'b01,
    ModeMax    = 2'b10,
    ModeRsvd   = 2'b11
  } med_mode_e;

  typedef enum logic [3:0] {
    StIdle,
    StRow0,
    StRow1,
    StRow2,
    StCap1,
    StS2Min,
    StS2Med,
    StS2Max,
    StCap2,
    StFin,
    StDone
  } med9_state_e;

endpackage

// File: rtl/median9_sched_if.sv
// Window-in / statistic-out bus of median9_sched.
interface median9_sched_if #(
  parameter int unsigned WIDTH = median_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [1:0]       mode;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, mode,
    input  in_ready, result, out_valid, busy
  );

  modport slave (
    input  in_valid, p0, p1, p2, p3, p4, p5, p6, p7, p8, mode,
    output in_ready, result, out_valid, busy
  );
endinterface

// File: rtl/sort3.sv
// Registered 3-input sorter: min/med/max one clock after the inputs.
module sort3 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] med,
  output logic [WIDTH-1:0] max
);

  logic [WIDTH-1:0] lo1, hi1, t, mx, mn, md;

  // Strict compares keep ties in a, b, c order.
  always_comb begin
    lo1 = (b < a) ? b : a;
    hi1 = (b < a) ? a : b;
    mx  = (c < hi1) ? hi1 : c;
    t   = (c < hi1) ? c : hi1;
    mn  = (t < lo1) ? t : lo1;
    md  = (t < lo1) ? lo1 : t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min <= '0;
      med <= '0;
      max <= '0;
    end else begin
      min <= mn;
      med <= md;
      max <= mx;
    end
  end

endmodule

// File: rtl/median9_sched.sv
// 3x3 median/min/max using one time-shared sort3: three row sorts, three
// column-of-statistics sorts, then a final sort of (lo, mid, hi).
module median9_sched
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  median9_sched_if.slave bus
);

  med9_state_e      state_q, state_d;
  med_mode_e        mode_q;
  logic [WIDTH-1:0] px_in [9];
  logic [WIDTH-1:0] px_q  [9];
  logic [WIDTH-1:0] rmin_q [3];
  logic [WIDTH-1:0] rmed_q [3];
  logic [WIDTH-1:0] rmax_q [3];
  logic [WIDTH-1:0] lo_q, mid_q, hi_q, gmin_q, gmax_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] sa, sb, sc, s_min, s_med, s_max;
  logic             accept;

  assign px_in[0] = bus.p0;
  assign px_in[1] = bus.p1;
  assign px_in[2] = bus.p2;
  assign px_in[3] = bus.p3;
  assign px_in[4] = bus.p4;
  assign px_in[5] = bus.p5;
  assign px_in[6] = bus.p6;
  assign px_in[7] = bus.p7;
  assign px_in[8] = bus.p8;

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.busy      = (state_q != StIdle);
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRow0;
      StRow0:  state_d = StRow1;
      StRow1:  state_d = StRow2;
      StRow2:  state_d = StCap1;
      StCap1:  state_d = StS2Min;
      StS2Min: state_d = StS2Med;
      StS2Med: state_d = StS2Max;
      StS2Max: state_d = StCap2;
      StCap2:  state_d = StFin;
      StFin:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sa = '0;
    sb = '0;
    sc = '0;
    unique case (state_q)
      StRow0:  begin sa = px_q[0];   sb = px_q[1];   sc = px_q[2];   end
      StRow1:  begin sa = px_q[3];   sb = px_q[4];   sc = px_q[5];   end
      StRow2:  begin sa = px_q[6];   sb = px_q[7];   sc = px_q[8];   end
      StS2Min: begin sa = rmin_q[0]; sb = rmin_q[1]; sc = rmin_q[2]; end
      StS2Med: begin sa = rmed_q[0]; sb = rmed_q[1]; sc = rmed_q[2]; end
      StS2Max: begin sa = rmax_q[0]; sb = rmax_q[1]; sc = rmax_q[2]; end
      StFin:   begin sa = lo_q;      sb = mid_q;     sc = hi_q;      end
      default: ;
    endcase
  end

  sort3 #(.WIDTH(WIDTH)) u_sort3 (
    .clk (clk),
    .rst (rst),
    .a   (sa),
    .b   (sb),
    .c   (sc),
    .min (s_min),
    .med (s_med),
    .max (s_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= ModeMedian;
      lo_q        <= '0;
      mid_q       <= '0;
      hi_q        <= '0;
      gmin_q      <= '0;
      gmax_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) px_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        rmin_q[i] <= '0;
        rmed_q[i] <= '0;
        rmax_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      // Each capture takes the sorter output issued in the previous state.
      unique case (state_q)
        StIdle: if (accept) begin
          for (int i = 0; i < 9; i++) px_q[i] <= px_in[i];
          mode_q <= med_mode_e'(bus.mode);
        end
        StRow1:  begin rmin_q[0] <= s_min; rmed_q[0] <= s_med; rmax_q[0] <= s_max; end
        StRow2:  begin rmin_q[1] <= s_min; rmed_q[1] <= s_med; rmax_q[1] <= s_max; end
        StCap1:  begin rmin_q[2] <= s_min; rmed_q[2] <= s_med; rmax_q[2] <= s_max; end
        StS2Med: begin lo_q <= s_max; gmin_q <= s_min; end
        StS2Max: mid_q <= s_med;
        StCap2:  begin hi_q <= s_min; gmax_q <= s_max; end
        StDone: begin
          out_valid_q <= 1'b1;
          case (mode_q)
            ModeMin: result_q <= gmin_q;
            ModeMax: result_q <= gmax_q;
            default: result_q <= s_med;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
